// File: rtl/cdc_hs_tx_ctrl_if.sv
// Handshake bundle between the local producer, the source controller and the destination domain.
// master = controller view, slave = environment (producer + destination) view.
interface cdc_hs_tx_ctrl_if #(
  parameter int W = 16
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         x_req;
  logic [W-1:0] x_data;
  logic         x_ack;

  modport master (
    input  s_valid,
    input  s_data,
    input  x_ack,
    output s_ready,
    output x_req,
    output x_data
  );

  modport slave (
    output s_valid,
    output s_data,
    output x_ack,
    input  s_ready,
    input  x_req,
    input  x_data
  );
endinterface

// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a four-phase req/ack word transfer into another clock domain,
// with a sticky per-phase stall timeout and a completed-transfer counter.
//
// state | meaning
// IDLE  | waiting for a producer word; blocked while the synchronised ack is still high
// REQ   | x_req high, x_data held, waiting for ack_s to rise
// REL   | x_req low, x_data still held, waiting for ack_s to fall
module cdc_hs_tx_ctrl #(
  parameter int W       = 16,
  parameter int CW      = 8,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  cdc_hs_tx_ctrl_if.master     hs,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  input  logic                 timeout_clr,
  output logic [CW-1:0]        xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic          ack_m;
  logic          ack_s;
  logic          ready_c;
  logic          busy_c;
  logic          accept;
  logic          req_drop;
  logic          finish;
  logic          waiting;
  logic          req_q;
  logic [W-1:0]  data_q;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;
  logic          cnt_run;

  // x_ack is asynchronous; only the second flop is ever looked at
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= hs.x_ack;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs.s_valid && !ack_s) state_nxt = REQ;
      REQ:     if (ack_s)                state_nxt = REL;
      REL:     if (!ack_s)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c  = 1'b0;
    busy_c   = 1'b1;
    accept   = 1'b0;
    req_drop = 1'b0;
    finish   = 1'b0;
    waiting  = 1'b0;
    case (state)
      IDLE: begin
        busy_c  = 1'b0;
        ready_c = !ack_s;
        accept  = hs.s_valid && !ack_s;
      end
      REQ: begin
        waiting  = 1'b1;
        req_drop = ack_s;
      end
      REL: begin
        waiting = 1'b1;
        finish  = !ack_s;
      end
      default: busy_c = 1'b0;
    endcase
  end

  assign hs.s_ready = ready_c;
  assign busy       = busy_c;
  assign hs.x_req   = req_q;
  assign hs.x_data  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q    <= 1'b0;
      data_q   <= '0;
      done     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        req_q  <= 1'b1;
        data_q <= hs.s_data;
      end else if (req_drop) begin
        req_q <= 1'b0;
      end
      if (finish) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  // Counter restarts on every phase entry; transition cycles do not count toward a stall
  assign cnt_run    = waiting && !req_drop && !finish;
  assign to_cnt_nxt = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (timeout_clr || !cnt_run) to_cnt <= '0;
      else                         to_cnt <= to_cnt_nxt;

      if (timeout_clr)                          timeout <= 1'b0;
      else if (cnt_run && to_cnt_nxt == TO_MAX) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Bench for cdc_hs_tx_ctrl: directed timing phases plus random traffic, with a
// scoreboard monitor comparing every presented word and completion count.
module tb_cdc_hs_tx_ctrl;
  localparam int W       = 16;
  localparam int CW      = 8;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          timeout_clr = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] xfer_cnt;
  logic          loop = 1'b0;
  logic          ack_drv = 1'b0;

  cdc_hs_tx_ctrl_if #(.W(W)) bus ();

  assign bus.x_ack = loop ? bus.x_req : ack_drv;

  cdc_hs_tx_ctrl #(.W(W), .CW(CW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (bus),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .timeout_clr (timeout_clr),
    .xfer_cnt    (xfer_cnt)
  );

  initial forever #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_word = '0;
  logic         prev_req = 1'b0;
  logic         prev_done = 1'b0;
  int           done_total = 0;
  int           done_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a new request must carry the next offered word, the word must
  // then stay put until the next request, and each done advances the modular count.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      last_word  = '0;
      prev_req   = 1'b0;
      prev_done  = 1'b0;
      done_model = 0;
    end else begin
      if (bus.x_req && !prev_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", 32'(1), 32'(0));
        else begin
          last_word = exp_q.pop_front();
          chk("x_data_word", 32'(bus.x_data), 32'(last_word));
        end
      end else begin
        chk("x_data_hold", 32'(bus.x_data), 32'(last_word));
      end
      if (done) begin
        done_model++;
        done_total++;
        chk("xfer_cnt", 32'(xfer_cnt), 32'(done_model % (1 << CW)));
        chk("done_single", 32'(prev_done), 32'(0));
      end
      prev_req  = bus.x_req;
      prev_done = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    exp_q.push_back(w);
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("send_wait", 32'(0), 32'(1));
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_total < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_done", 32'(done_total >= target), 32'(1));
  endtask

  task automatic responder();
    int n;
    n = 0;
    while (!bus.x_req && n < 400) begin @(negedge clk); n++; end
    if (!bus.x_req) chk("resp_req_rise", 32'(0), 32'(1));
    repeat ($urandom_range(1, 20)) @(negedge clk);
    ack_drv = 1'b1;
    n = 0;
    while (bus.x_req && n < 400) begin @(negedge clk); n++; end
    if (bus.x_req) chk("resp_req_fall", 32'(0), 32'(1));
    repeat ($urandom_range(1, 20)) @(negedge clk);
    ack_drv = 1'b0;
  endtask

  logic [7:0] req_h, done_h, rdy_h;
  logic [CW-1:0] cnt6;
  logic th[0:16];
  logic ok, r1, r2;
  int base;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_x_req",   32'(bus.x_req),   32'(0));
    chk("rst_x_data",  32'(bus.x_data),  32'(0));
    chk("rst_done",    32'(done),        32'(0));
    chk("rst_timeout", 32'(timeout),     32'(0));
    chk("rst_xfer",    32'(xfer_cnt),    32'(0));
    chk("rst_busy",    32'(busy),        32'(0));
    chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // loopback latency with 0xA5A5 held valid
    loop = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hA5A5;
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'hA5A5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_h[i]  = bus.x_req;
      done_h[i] = done;
      rdy_h[i]  = bus.s_ready;
      if (i == 6) cnt6 = xfer_cnt;
    end
    bus.s_valid = 1'b0;
    chk("lb_req_shape",  32'(req_h),  32'(8'b1000_0111));
    chk("lb_done_shape", 32'(done_h), 32'(8'b0100_0000));
    chk("lb_rdy_shape",  32'(rdy_h),  32'(8'b0100_0000));
    chk("lb_cnt_first",  32'(cnt6),   32'(1));
    wait_done(2, 20);
    chk("lb_cnt_second", 32'(xfer_cnt), 32'(2));

    // 300 back-to-back loopback words
    do_reset();
    loop = 1'b1;
    base = done_total;
    for (int i = 0; i < 300; i++) send(W'($urandom));
    wait_done(base + 300, 50);
    chk("b2b_dones", 32'(done_total - base), 32'(300));
    chk("b2b_wrap",  32'(xfer_cnt), 32'(300 % 256));

    // stall timeout with ack stuck low
    do_reset();
    loop = 1'b0;
    ack_drv = 1'b0;
    base = done_total;
    send(W'($urandom));
    chk("to_busy", 32'(busy), 32'(1));
    chk("to_req",  32'(bus.x_req), 32'(1));
    for (int i = 1; i <= 16; i++) begin @(negedge clk); th[i] = timeout; end
    chk("to_early", 32'(th[15]), 32'(0));
    chk("to_at16",  32'(th[16]), 32'(1));
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("to_cleared", 32'(timeout), 32'(0));
    for (int i = 1; i <= 16; i++) begin @(negedge clk); th[i] = timeout; end
    chk("to_re_early", 32'(th[15]), 32'(0));
    chk("to_re_at16",  32'(th[16]), 32'(1));
    ack_drv = 1'b1;
    for (int i = 0; i < 10 && bus.x_req; i++) @(negedge clk);
    chk("to_req_drop", 32'(bus.x_req), 32'(0));
    ack_drv = 1'b0;
    wait_done(base + 1, 20);
    chk("to_sticky", 32'(timeout), 32'(1));
    chk("to_xfer",   32'(xfer_cnt), 32'(1));

    // stale ack high from reset blocks acceptance
    loop = 1'b0;
    ack_drv = 1'b1;
    do_reset();
    base = done_total;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h3C5A;
    exp_q.push_back(16'h3C5A);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.s_ready || bus.x_req || busy) ok = 1'b0;
    end
    chk("stale_blocked", 32'(ok), 32'(1));
    ack_drv = 1'b0;
    @(negedge clk); r1 = bus.s_ready;
    @(negedge clk); r2 = bus.s_ready;
    chk("stale_rdy_1", 32'(r1), 32'(0));
    chk("stale_rdy_2", 32'(r2), 32'(1));
    loop = 1'b1;
    @(negedge clk);
    chk("stale_accept", 32'(bus.x_req), 32'(1));
    bus.s_valid = 1'b0;
    wait_done(base + 1, 20);

    // asynchronous reset while in REQ
    do_reset();
    loop = 1'b1;
    base = done_total;
    send(W'($urandom));
    wait_done(base + 1, 20);
    loop = 1'b0;
    ack_drv = 1'b0;
    send(W'($urandom));
    @(negedge clk);
    chk("ar_busy_pre", 32'(busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("ar_req",  32'(bus.x_req), 32'(0));
    chk("ar_busy", 32'(busy),      32'(0));
    chk("ar_xfer", 32'(xfer_cnt),  32'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ar_idle_busy",  32'(busy),        32'(0));
    chk("ar_idle_ready", 32'(bus.s_ready), 32'(1));

    // random destination delays
    do_reset();
    loop = 1'b0;
    ack_drv = 1'b0;
    base = done_total;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(W'($urandom));
        end
      end
      begin
        for (int j = 0; j < 40; j++) responder();
      end
    join
    wait_done(base + 40, 40);
    chk("rnd_dones", 32'(done_total - base), 32'(40));
    chk("rnd_xfer",  32'(xfer_cnt), 32'(40));
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
